anubis_key_evolution: RTL
=========================

# anubis_key_evolution

Sequential Anubis key-evolution engine for the 128-bit key configuration (N = 4). It runs directly upstream of the `Round_Constants` stage. Each cycle it drives `round_counter` to that stage and consumes the returned 128-bit round constant c^r. It then produces the evolved keys K^0..K^ROUNDS, one per cycle, for the round-key extraction stage downstream.

## Interface
- `ROUNDS`, default 12: number of evolution steps. Must be in 1..15, to fit the 4-bit counter.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: one-cycle request. Sampled only in IDLE.
- `key_in` input 128: cipher key K^0. Byte k occupies bits [127-8k -: 8].
- `round_counter` output 4: round number r sent to `Round_Constants`.
- `rc_in` input 128: c^r returned combinationally by `Round_Constants` for the current `round_counter`.
- `key_valid` output 1: `key_out` holds K^`key_index` this cycle.
- `key_index` output 4: round index of `key_out`, 0..ROUNDS.
- `key_out` output 128: evolved key K^r.
- `busy` output 1: high from the cycle after an accepted `start` until the cycle after `done`.
- `done` output 1: one-cycle pulse, coincident with the K^ROUNDS output.

## Operation
- Matrix view: byte k = a[i][j] with i = k/4 (row) and j = k%4 (column), row-major. The top row is bits [127:96].
- Evolution per step: K^r = σ[c^r](θ(π(γ(K^{r-1})))), for r = 1..ROUNDS.
  - γ: each of the 16 bytes goes through the codebase `Sbox`, which uses the AES table.
  - π: b[i][j] = a[(i-j) mod 4][j]. Column j rotates down by j.
  - θ: b = a·H, so b[i][j] = XOR over m of a[i][m]·h[m][j], with h[m][j] = t[m XOR j] and t = (01,02,04,06).
    - Multiplication is in GF(2^8) mod x^8+x^4+x^3+x^2+1 (0x11D).
  - σ: bytewise XOR with `rc_in`.
- FSM states: IDLE and RUN.
  - IDLE, `start`=1: register `key_in` into the key register, set r = 1, go to RUN.
  - RUN: output the key register with index r-1.
    - If r-1 < ROUNDS: register the evolved value and increment r.
    - If r-1 = ROUNDS: assert `done` and return to IDLE.
- `start` during RUN is ignored. There is no queueing.
- `round_counter` = r while in RUN and 0 in IDLE. `rc_in` is ignored in IDLE and in the final RUN cycle.
- Only one combinational evolution step sits between key-register stages.
- Reset, including mid-run, forces:
  - state IDLE, r = 0, key register 0;
  - `key_valid`, `busy`, `done` = 0;
  - `key_out` = 0, `key_index` = 0, `round_counter` = 0.
  - No partial sequence resumes after reset is released.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: `busy`=1, `key_valid`=1, `key_index`=0, `key_out`=K^0, `round_counter`=1.
- Cycle 1+r, for r = 1..ROUNDS: `key_index`=r, `key_out`=K^r, `round_counter`=r+1.
  - In the last of these cycles, `round_counter` stays at ROUNDS+1 (value is don't-care to the downstream stage).
- Cycle 1+ROUNDS: `done`=1.
- Cycle 2+ROUNDS: `key_valid`=0 and `busy`=0. A new `start` is accepted in this cycle.
- `key_valid` is high for exactly ROUNDS+1 consecutive cycles.
- `key_out` and `key_index` are registered. They hold their last values while `key_valid`=0; consumers must gate on `key_valid`.
- Throughput: one key per cycle. Total occupancy is ROUNDS+2 cycles from `start` to the next accept.

## Test plan
- All-zero key, ROUNDS=12, real `Round_Constants` attached:
  - K^0 = 0.
  - K^1 = 001F1418 63636363 63636363 63636363.
  - Each row of θ(0x63) is 0x63, since 01⊕02⊕04⊕06 = 01.
- Handshake timing:
  - `key_valid` high for exactly 13 cycles.
  - `key_index` steps 0..12 with no gaps.
  - `done` high only in the K^12 cycle.
  - `round_counter` steps 1..12 aligned as specified.
- `start` pulsed every cycle during RUN: the sequence is unaffected and there is no restart.
  - Back-to-back `start` in the cycle after `done` begins a new run with no idle gap.
- Random keys (≥100), compared against a software Anubis key-evolution model: all 13 keys match bit-exactly.
- `rst` asserted asynchronously mid-cycle at `key_index`=5:
  - all outputs read 0 immediately;
  - after release, no `key_valid` appears until a new `start`;
  - the new run starts from K^0 of the new `key_in`.
- `key_in` changed during RUN: no effect on the current sequence. The key is captured only at `start` acceptance.

Source files
------------

// File: rtl/anubis_key_evolution.sv
// anubis_key_evolution
// Sequential Anubis key-evolution engine for 128-bit keys (N = 4). It emits
// K^0..K^ROUNDS, one key per cycle. Round constants come from an external
// Round_Constants stage, addressed through round_counter.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          one-cycle request, sampled only while idle
//   key_in         cipher key K^0 (byte k at [127-8k -: 8])
//   round_counter  round number r presented to Round_Constants (0 when idle)
//   rc_in          round constant c^r returned combinationally for round_counter
//   key_valid      key_out holds K^key_index this cycle
//   key_index      round index of key_out
//   key_out        evolved key K^r
//   busy           engine occupied
//   done           one-cycle pulse alongside K^ROUNDS
module anubis_key_evolution #(
  parameter int unsigned ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [3:0]   round_counter,
  input  logic [127:0] rc_in,
  output logic         key_valid,
  output logic [3:0]   key_index,
  output logic [127:0] key_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KW = 128;
  localparam int unsigned CW = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CW-1:0] LAST = CW'(ROUNDS);

  // AES substitution table used by the gamma layer
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x modulo x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  // Multiply by t[sel], t = (01, 02, 04, 06)
  function automatic logic [7:0] mul_t(input logic [7:0] x, input logic [1:0] sel);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] y;
    x2 = xtime(x);
    x4 = xtime(x2);
    case (sel)
      2'd0:    y = x;
      2'd1:    y = x2;
      2'd2:    y = x4;
      default: y = x4 ^ x2;
    endcase
    return y;
  endfunction

  // One evolution step: sigma(theta(pi(gamma(k)))). Byte (i,j) sits at index 4i+j.
  function automatic logic [KW-1:0] evolve(input logic [KW-1:0] k, input logic [KW-1:0] rc);
    logic [KW-1:0] g;
    logic [KW-1:0] p;
    logic [KW-1:0] h;
    logic [7:0]    acc;
    g = '0;
    p = '0;
    h = '0;
    for (int n = 0; n < 16; n++) begin
      g[127-8*n -: 8] = SBOX[k[127-8*n -: 8]];
    end
    // column j rotates down by j
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        p[127-8*(4*i+j) -: 8] = g[127-8*(4*((i-j+4)%4)+j) -: 8];
      end
    end
    // H is circulant in the XOR sense: h[m][j] = t[m^j]
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int m = 0; m < 4; m++) begin
          acc = acc ^ mul_t(p[127-8*(4*i+m) -: 8], 2'(m ^ j));
        end
        h[127-8*(4*i+j) -: 8] = acc;
      end
    end
    return h ^ rc;
  endfunction

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] r_q, r_d;
  logic [KW-1:0] key_q, key_d;
  logic [CW-1:0] index_q, index_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [KW-1:0] evolved_c;

  assign evolved_c = evolve(key_q, rc_in);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      key_q   <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      key_q   <= key_d;
      index_q <= index_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; index_q always equals r-1 while running
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    key_d   = key_q;
    index_d = index_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          r_d     = CW'(1);
          key_d   = key_in;
          index_d = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (index_q != LAST) begin
          key_d   = evolved_c;
          index_d = index_q + CW'(1);
          r_d     = r_q + CW'(1);
          done_d  = (index_q + CW'(1)) == LAST;
        end else begin
          // key_out/key_index hold their final values while idle
          state_d = S_IDLE;
          r_d     = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign key_out       = key_q;
  assign key_index     = index_q;
  assign round_counter = r_q;
  assign key_valid     = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
